// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus
interface imem_loader_if #(parameter int ADDR_W = 10);
  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: unpacks a framed, XOR-checked byte stream into 32-bit instruction words
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  state_t            state, nxt;
  logic [15:0]       n, cnt, n_full;
  logic [23:0]       word;
  logic [1:0]        bidx;
  logic [7:0]        chk;
  logic [ADDR_W-1:0] widx, addr_q;
  logic [31:0]       wdata_q;
  logic              we_q, ready, acc, restart;
  always_comb begin
    nxt = state;
    ready = 1'b0;
    n_full = {n[15:8], bus.byte_data};
    case (state)
      IDLE: nxt = start ? LEN_HI : IDLE;
      LEN_HI: begin
        ready = 1'b1;
        nxt = bus.byte_valid ? LEN_LO : LEN_HI;
      end
      LEN_LO: begin
        ready = 1'b1;
        if (bus.byte_valid)
          nxt = ({1'b0, n_full} > DEPTH_L) ? ERR : (n_full == 16'd0) ? CHK : DATA;
      end
      DATA: begin
        ready = 1'b1;
        if (bus.byte_valid && bidx == 2'd3 && cnt == n - 16'd1) nxt = CHK;
      end
      CHK: begin
        ready = 1'b1;
        if (bus.byte_valid) nxt = (bus.byte_data == chk) ? DONE : ERR;
      end
      DONE, ERR: nxt = start ? LEN_HI : state;
      default: nxt = IDLE;
    endcase
  end
  assign acc            = bus.byte_valid & ready;
  assign restart        = start & (state == IDLE || state == DONE || state == ERR);
  assign bus.byte_ready = ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  // done/cpu_hold react to start combinationally so the CPU is re-held in the start cycle
  assign done     = (state == DONE) & ~start;
  assign cpu_hold = ~done;
  assign error    = state == ERR;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      n       <= '0;
      cnt     <= '0;
      word    <= '0;
      bidx    <= '0;
      chk     <= '0;
      widx    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= nxt;
      we_q  <= 1'b0;
      if (restart) begin
        cnt  <= '0;
        bidx <= '0;
        chk  <= '0;
        widx <= '0;
      end
      if (acc && state == LEN_HI) n[15:8] <= bus.byte_data;
      if (acc && state == LEN_LO) n[7:0] <= bus.byte_data;
      if (acc && state == DATA) begin
        word <= {word[15:0], bus.byte_data};
        chk  <= chk ^ bus.byte_data;
        bidx <= bidx + 2'd1;
        if (bidx == 2'd3) begin
          we_q    <= 1'b1;
          wdata_q <= {word, bus.byte_data};
          addr_q  <= widx;
          widx    <= widx + 1'b1;
          cnt     <= cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames; a negedge monitor scores memory writes against a queue
module tb_imem_loader;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, is4th = 1'b0, pend = 1'b0;
  logic cpu_hold, done, error;
  int checks = 0, errors = 0;
  logic [41:0] exp_q[$];
  logic [41:0] e;
  logic [31:0] img [2];
  imem_loader_if #(.ADDR_W(10)) bus ();
  imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // a write must appear exactly one cycle after each accepted 4th data byte
  always @(negedge clk) begin
    if (bus.mem_we || pend) begin
      checks++;
      if (bus.mem_we !== pend) begin
        errors++;
        $display("FAIL we_timing: mem_we %b expected %b at %0t", bus.mem_we, pend, $time);
      end
    end
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h expected none", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got %h/%h expected %h/%h", bus.mem_addr, bus.mem_wdata, e[41:32], e[31:0]);
        end
      end
    end
    pend = bus.byte_valid & bus.byte_ready & is4th;
  end
  task automatic send(input logic [7:0] b, input logic f4, input logic gap);
    bit ok = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    is4th = f4;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.byte_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
    is4th = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic send_image(input logic [7:0] chk_mod, input logic gap, input logic mid_start);
    logic [7:0] c, d;
    c = 8'h00;
    send(8'h00, 1'b0, gap);
    send(8'h02, 1'b0, gap);
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 4; b++) begin
        d = img[w][31-8*b -: 8];
        c = c ^ d;
        if (b == 3) exp_q.push_back({10'(w), img[w]});
        if (mid_start && w == 0 && b == 2) start = 1'b1;
        send(d, b == 3, gap);
        start = 1'b0;
      end
    send(c ^ chk_mod, 1'b0, gap);
  endtask
  task automatic result(input string tag, input logic d, input logic er, input logic h);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(er));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
  endtask
  initial begin
    img[0] = 32'h20080005;
    img[1] = 32'h8C090004;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    #12;
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done_err", {30'd0, done, error}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    // good image (XOR of the data bytes is 8'hAC)
    do_start();
    send_image(8'h00, 1'b0, 1'b0);
    result("c1", 1'b1, 1'b0, 1'b0);
    // bad checksum; done and cpu_hold must react within the start cycle
    start = 1'b1;
    @(negedge clk);
    check("start_done_drop", 32'(done), 32'd0);
    check("start_hold_rise", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    send_image(8'h01, 1'b0, 1'b0);
    result("c2", 1'b0, 1'b1, 1'b1);
    // oversize length
    do_start();
    check("c3_err_cleared", 32'(error), 32'd0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    result("c3", 1'b0, 1'b1, 1'b1);
    check("c3_ready", 32'(bus.byte_ready), 32'd0);
    // empty image
    do_start();
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    result("c4", 1'b1, 1'b0, 1'b0);
    // stalled stream with an ignored mid-frame start
    do_start();
    send_image(8'h00, 1'b1, 1'b1);
    result("c5", 1'b1, 1'b0, 1'b0);
    // asynchronous reset after six data bytes
    do_start();
    send(8'h00, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) exp_q.push_back({10'd0, img[0]});
      send(img[0][31-8*b -: 8], b == 3, 1'b0);
    end
    send(8'h8C, 1'b0, 1'b0);
    send(8'h09, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_ready", 32'(bus.byte_ready), 32'd0);
    check("arst_we", 32'(bus.mem_we), 32'd0);
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_wdata", bus.mem_wdata, 32'd0);
    check("arst_flags", {29'd0, cpu_hold, done, error}, 32'd4);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    do_start();
    send_image(8'h00, 1'b0, 1'b0);
    result("c6", 1'b1, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
